// File: rtl/fwd_sel_ctrl.sv
// Purpose : Forwarding and operand-select controller for the EX-stage operand muxes,
//           with load-use stall detection.
// Latency : sel_a/sel_b/ex_valid are registered, 1 cycle after decode; stall is combinational.
// Backpr. : hold freezes all state; stall asks fetch/decode to re-present the same instruction.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   hold                     global freeze; all state retained, ID/flush ignored
//   flush                    kill the instruction entering EX
//   id_valid, id_rs1/rs2,    decode-stage instruction description
//   id_use_rs1/rs2, id_use_pc, id_use_imm, id_rd, id_we, id_is_load
//   sel_a, sel_b             operand-mux select codes valid in EX
//   stall                    load-use stall request (same cycle)
//   ex_valid                 EX stage holds a real instruction
module fwd_sel_ctrl #(
  parameter int REG_W = 5,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_use_pc,
  input  logic             id_use_imm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  output logic [SEL_W-1:0] sel_a,
  output logic [SEL_W-1:0] sel_b,
  output logic             stall,
  output logic             ex_valid
);

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);  // register file
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(1);  // MEM-stage ALU result
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(2);  // WB-stage result
  localparam logic [SEL_W-1:0] SEL_IMM = SEL_W'(3);  // immediate
  localparam logic [SEL_W-1:0] SEL_PC  = SEL_W'(4);  // program counter

  // Scoreboard. The EX entry (ex_valid/ex_rd/ex_we/ex_ld) describes the
  // instruction now in EX, the MEM entry the one ahead of it. The WB entry
  // would only ever be shifted out and never feeds a decision (distance 3+
  // reads come through the regfile write-through), so it is not stored.
  logic [REG_W-1:0] ex_rd;
  logic             ex_we;
  logic             ex_ld;
  logic             mem_valid;
  logic [REG_W-1:0] mem_rd;
  logic             mem_we;

  logic             ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic             load_use;
  logic             kill;
  logic [SEL_W-1:0] sel_a_nxt, sel_b_nxt;

  // An entry "writes r" only for a real, writing instruction; x0 never matches.
  function automatic logic writes(input logic v, input logic we,
                                  input logic [REG_W-1:0] rd,
                                  input logic [REG_W-1:0] r);
    return v & we & (rd == r) & (r != '0);
  endfunction

  always_comb begin
    ex_hit1  = id_use_rs1 & writes(ex_valid, ex_we, ex_rd, id_rs1);
    ex_hit2  = id_use_rs2 & writes(ex_valid, ex_we, ex_rd, id_rs2);
    mem_hit1 = id_use_rs1 & writes(mem_valid, mem_we, mem_rd, id_rs1);
    mem_hit2 = id_use_rs2 & writes(mem_valid, mem_we, mem_rd, id_rs2);

    // A load in EX has no result until after MEM, so a dependent instruction
    // cannot forward from it next cycle.
    load_use = id_valid & ex_ld & (ex_hit1 | ex_hit2);
    stall    = load_use & ~flush & ~hold & ~rst;
    // Flush kills regardless of the hazard, so the bubble is the same either way.
    kill     = flush | load_use;

    // The instruction in EX now is distance 1, so during the next cycle it
    // sits in MEM; the one in MEM now will sit in WB. Newer value wins.
    sel_a_nxt = SEL_RF;
    if (id_use_pc)     sel_a_nxt = SEL_PC;
    else if (ex_hit1)  sel_a_nxt = SEL_MEM;
    else if (mem_hit1) sel_a_nxt = SEL_WB;

    sel_b_nxt = SEL_RF;
    if (id_use_imm)    sel_b_nxt = SEL_IMM;
    else if (ex_hit2)  sel_b_nxt = SEL_MEM;
    else if (mem_hit2) sel_b_nxt = SEL_WB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_ld     <= 1'b0;
      mem_valid <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      sel_a     <= SEL_RF;
      sel_b     <= SEL_RF;
    end else if (!hold) begin
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_we    <= ex_we;
      if (kill) begin
        ex_valid <= 1'b0;
        ex_rd    <= '0;
        ex_we    <= 1'b0;
        ex_ld    <= 1'b0;
        sel_a    <= SEL_RF;
        sel_b    <= SEL_RF;
      end else begin
        ex_valid <= id_valid;
        ex_rd    <= id_rd;
        ex_we    <= id_we;
        ex_ld    <= id_is_load;
        sel_a    <= sel_a_nxt;
        sel_b    <= sel_b_nxt;
      end
    end
  end

endmodule

// File: doc/fwd_sel_ctrl.md
# fwd_sel_ctrl

Forwarding and operand-select controller for the 5-stage pipeline: generates the 3-bit select codes consumed by the two 5:1 EX-stage operand multiplexers (op_a, op_b) and the load-use stall. Sits between decode and EX. It tracks the destination register of every in-flight instruction in an internal EX/MEM/WB scoreboard and registers the select codes so they are valid during the instruction's EX cycle.

## Interface
Parameters:
- REG_W, 5, register-index width
- SEL_W, 3, select-code width (matches operand muxes)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  global pipeline freeze (e.g. memory wait)
- flush  in  1  kill instruction entering EX (taken branch/jump)
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2  in  REG_W  source register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_use_pc  in  1  op_a takes PC (AUIPC/JAL)
- id_use_imm  in  1  op_b takes immediate
- id_rd  in  REG_W  destination index
- id_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- sel_a, sel_b  out  SEL_W  registered operand-mux selects, valid in EX
- stall  out  1  load-use stall request to fetch/decode
- ex_valid  out  1  EX stage holds a real instruction

## Operation
- Select codes: 000 regfile, 001 forward MEM-stage ALU result, 010 forward WB-stage result, 011 immediate, 100 PC. Codes 101-111 never driven.
- Scoreboard: three entries (EX, MEM, WB) of {valid, rd, we, is_load}. Each non-held edge shifts ID→EX→MEM→WB; WB entry discarded.
- An entry "writes r" iff valid & we & rd==r & r!=0. x0 is never forwarded.
- sel_a next: id_use_pc → 100; else rs1 written by current EX entry → 001; else written by current MEM entry → 010; else 000. EX entry has priority (newer value).
- sel_b next: id_use_imm → 011; else same forwarding rule on rs2.
- Forwarding only evaluated for used sources (id_use_rsN); unused source → 000 (or 011/100 as above).
- stall (combinational) = id_valid & EX entry is_load & writes(id_rs1 with id_use_rs1, or id_rs2 with id_use_rs2) & ~flush & ~hold.
- On stall: EX entry loaded as bubble (valid 0, sel 000); MEM/WB shift normally; upstream re-presents same ID instruction next cycle, which then forwards from WB (010).
- On flush (hold low): EX entry loaded as bubble, sel 000; flush overrides stall.
- On hold: all scoreboard and output registers retain value; flush/id inputs ignored that cycle.
- Priority: rst > hold > flush > stall > normal.

## Timing
- Reset: all entries valid 0; sel_a=000, sel_b=000, ex_valid=0, stall=0 from the first cycle after rst sampled high. Reset mid-operation discards all in-flight entries.
- Latency: decode inputs in cycle t → sel_a/sel_b/ex_valid valid in cycle t+1 (1 cycle).
- stall is same-cycle combinational from ID inputs and EX entry; asserted for exactly one cycle per load-use hazard (unless held).
- Back-to-back dependent ALU ops: no stall, 001. Distance 2: 010. Distance 3+: 000 (regfile write-through handles it).
- Load followed at distance 2: no stall, 010.

## Test plan
- Reset: rst high 2 cycles with id_valid=1 → sel_a=sel_b=000, stall=0, ex_valid=0; first instr after release gives ex_valid=1 next cycle.
- ALU chain: add x5←..., then add x6←x5,x5 → second instr sel_a=sel_b=001; third instr reading x5 → 010; fourth → 000.
- Load-use: lw x7, then add x8←x7,x1 → stall=1 one cycle, EX bubble (ex_valid=0, sel 000); re-presented add gets sel_a=010, sel_b=000.
- x0 / immediates: writes to x0 followed by readers of x0 → 000; addi with id_use_imm → sel_b=011; auipc id_use_pc → sel_a=100.
- Flush vs stall: load-use hazard with flush=1 same cycle → stall=0, EX bubble; following instruction sees no forward from the killed one.
- Hold: hold=1 for 3 cycles mid-chain → sel/ex_valid frozen, stall=0; after release forwarding codes identical to unheld run.
